// File: rtl/conv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_packer
// Purpose  : Packs LANES result words from the result FIFO into one output beat
//            with valid/ready handshake. Optional macro: CONV_PACKER_ERR_EN.
// Revision : 1.0
// ============================================================================
module conv_result_packer #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    size_valid,
   input  logic [CNT_W-1:0]        output_size,
   input  logic                    fifo_empty,
   input  logic [DATA_W-1:0]       fifo_data,
   output logic                    fifo_en,
   input  logic                    out_ready,
   output logic [DATA_W*LANES-1:0] Dataout,
   output logic                    Valid,
   output logic [LANES-1:0]        lane_mask,
   output logic                    Done,
   output logic                    busy
`ifdef CONV_PACKER_ERR_EN
   ,
   output logic                    size_err
`endif
);

   localparam int CW = $clog2(LANES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               remaining_q, remaining_d;
   logic [CW-1:0]                  req_cnt_q, req_cnt_d;
   logic [CW-1:0]                  got_cnt_q, got_cnt_d;
   logic                           rd_pend_q, rd_pend_d;
   logic [LANES-1:0][DATA_W-1:0]   lanes_q, lanes_d;
   logic [LANES-1:0]               mask_q, mask_d;
   logic [CW-1:0]                  beat_target;
   logic                           fifo_en_w;

   // Widened compare keeps min() correct whatever the relation of CNT_W to LANES.
   assign beat_target = (32'(remaining_q) >= 32'(LANES)) ? CW'(LANES) : CW'(remaining_q);
   assign fifo_en_w   = (state_q == S_FILL) && !fifo_empty && (req_cnt_q < beat_target);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      req_cnt_d   = req_cnt_q;
      got_cnt_d   = got_cnt_q;
      rd_pend_d   = 1'b0;
      lanes_d     = lanes_q;
      mask_d      = mask_q;
      case (state_q)
         S_IDLE: begin
            if (size_valid) begin
               remaining_d = output_size;
               req_cnt_d   = '0;
               got_cnt_d   = '0;
               lanes_d     = '0;
               mask_d      = '0;
               state_d     = (output_size == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            if (fifo_en_w) begin
               req_cnt_d = req_cnt_q + CW'(1);
            end
            rd_pend_d = fifo_en_w;
            if (rd_pend_q) begin
               for (int k = 0; k < LANES; k++) begin
                  if (got_cnt_q == CW'(k)) begin
                     lanes_d[k] = fifo_data;
                  end
               end
               got_cnt_d = got_cnt_q + CW'(1);
               if ((got_cnt_q + CW'(1)) == beat_target) begin
                  for (int k = 0; k < LANES; k++) begin
                     mask_d[k] = (k < int'(beat_target));
                  end
                  state_d = S_SEND;
               end
            end
         end
         S_SEND: begin
            if (out_ready) begin
               remaining_d = remaining_q - CNT_W'(beat_target);
               req_cnt_d   = '0;
               got_cnt_d   = '0;
               lanes_d     = '0;
               mask_d      = '0;
               state_d     = (remaining_q == CNT_W'(beat_target)) ? S_DONE : S_FILL;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         req_cnt_q   <= '0;
         got_cnt_q   <= '0;
         rd_pend_q   <= 1'b0;
         lanes_q     <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         req_cnt_q   <= req_cnt_d;
         got_cnt_q   <= got_cnt_d;
         rd_pend_q   <= rd_pend_d;
         lanes_q     <= lanes_d;
         mask_q      <= mask_d;
      end
   end

`ifdef CONV_PACKER_ERR_EN
   logic err_q;

   // A start request is only legal from IDLE; anything else is flagged once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= size_valid && (state_q != S_IDLE);
      end
   end

   assign size_err = err_q;
`endif

   assign fifo_en   = fifo_en_w;
   assign Dataout   = lanes_q;
   assign lane_mask = mask_q;
   assign Valid     = (state_q == S_SEND);
   assign Done      = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_packer
// Purpose  : Directed, scoreboard-based bench for conv_result_packer.
// Revision : 1.0
// ============================================================================
module tb_conv_result_packer;

   localparam int DW = 32;
   localparam int L  = 4;
   localparam int CW = 8;

   logic              clk;
   logic              rst;
   logic              size_valid;
   logic [CW-1:0]     output_size;
   logic              fifo_empty;
   logic [DW-1:0]     fifo_data;
   logic              fifo_en;
   logic              out_ready;
   logic [DW*L-1:0]   Dataout;
   logic              Valid;
   logic [L-1:0]      lane_mask;
   logic              Done;
   logic              busy;
`ifdef CONV_PACKER_ERR_EN
   logic              size_err;
`endif

   conv_result_packer #(.DATA_W(DW), .LANES(L), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .size_valid  (size_valid),
      .output_size (output_size),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_en     (fifo_en),
      .out_ready   (out_ready),
      .Dataout     (Dataout),
      .Valid       (Valid),
      .lane_mask   (lane_mask),
      .Done        (Done),
      .busy        (busy)
`ifdef CONV_PACKER_ERR_EN
      ,
      .size_err    (size_err)
`endif
   );

   typedef struct {
      logic [DW*L-1:0] d;
      logic [L-1:0]    m;
   } beat_t;

   beat_t        sb[$];
   logic [DW-1:0] fq[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   int           t0     = 0;
   int           last_acc = -100;
   bit           tog_en = 1'b0;
   bit           phase  = 1'b0;
   bit           pop;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result FIFO model: read data appears the cycle after the strobe.
   initial begin
      fifo_data  = '0;
      fifo_empty = 1'b1;
      forever begin
         @(negedge clk);
         pop = fifo_en;
         if (fifo_en) chk("en_while_empty", fifo_empty, 1'b0);
         @(posedge clk);
         cyc++;
         phase = !phase;
         if (pop && fq.size() > 0) fifo_data <= fq.pop_front();
         #1 fifo_empty = (fq.size() == 0) || (tog_en && phase);
      end
   end

   // Beat checker: compare every accepted beat against the scoreboard.
   always @(negedge clk) begin
      if (rst && Valid && out_ready) begin
         last_acc = cyc;
         chk("sb_has_beat", (sb.size() != 0), 1'b1);
         if (sb.size() != 0) begin
            beat_t e;
            e = sb.pop_front();
            chk("beat_data", Dataout, e.d);
            chk("beat_mask", lane_mask, e.m);
         end
      end
   end

   task automatic preload(input int first, input int n);
      for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
      fifo_empty = (fq.size() == 0) || (tog_en && phase);
   endtask

   task automatic sb_frame(input int first, input int n);
      int i;
      i = 0;
      while (i < n) begin
         beat_t b;
         b.d = '0;
         b.m = '0;
         for (int k = 0; k < L && i < n; k++) begin
            b.d[k*DW +: DW] = DW'(first + i);
            b.m[k] = 1'b1;
            i++;
         end
         sb.push_back(b);
      end
   endtask

   task automatic start(input int n);
      size_valid  = 1'b1;
      output_size = CW'(n);
      t0 = cyc;
      @(negedge clk);
      size_valid = 1'b0;
   endtask

   task automatic wait_valid(output int tv);
      int k;
      k = 0;
      while (!Valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      tv = cyc;
      if (!Valid) chk("valid_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!Done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (Done) chk("done_latency", cyc, last_acc + 1);
      else      chk("done_timeout", 1'b0, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      int tv;
      logic [DW*L-1:0] hold_d;
      logic [L-1:0]    hold_m;
      rst = 1'b0; size_valid = 1'b0; output_size = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dataout", Dataout, '0);
      chk("rst_valid", Valid, 1'b0);
      chk("rst_mask", lane_mask, '0);
      chk("rst_done", Done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fifo_en", fifo_en, 1'b0);
`ifdef CONV_PACKER_ERR_EN
      chk("rst_size_err", size_err, 1'b0);
`endif
      rst = 1'b1;
      @(negedge clk);

      // Full frame of eight words, no backpressure
      preload(1, 8); sb_frame(1, 8); start(8);
      wait_valid(tv);
      chk("first_valid_lat", tv - t0, 6);
      chk("first_beat", Dataout, {32'd4, 32'd3, 32'd2, 32'd1});
      wait_done();

      // Partial final beat
      preload(1, 6); sb_frame(1, 6); start(6);
      wait_done();

      // Backpressure hold
      out_ready = 1'b0;
      preload(1, 8); sb_frame(1, 8); start(8);
      wait_valid(tv);
      hold_d = Dataout;
      hold_m = lane_mask;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", Valid, 1'b1);
         chk("hold_data", Dataout, hold_d);
         chk("hold_mask", lane_mask, hold_m);
         chk("hold_no_read", fifo_en, 1'b0);
      end
      out_ready = 1'b1;
      wait_done();

      // FIFO empty toggling during FILL
      tog_en = 1'b1;
      preload(1, 4); sb_frame(1, 4); start(4);
      wait_done();
      tog_en = 1'b0;

      // Zero-size frame
      start(0);
      chk("zero_done", Done, 1'b1);
      chk("zero_busy", busy, 1'b1);
      chk("zero_valid", Valid, 1'b0);
      @(negedge clk);
      chk("zero_done_end", Done, 1'b0);
      chk("zero_busy_end", busy, 1'b0);

      // Asynchronous reset while FILL is stalled with two lanes loaded
      preload(1, 2); start(4);
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      chk("pre_rst_data", Dataout, {32'd0, 32'd0, 32'd2, 32'd1});
      #2 rst = 1'b0;
      #1;
      chk("arst_dataout", Dataout, '0);
      chk("arst_valid", Valid, 1'b0);
      chk("arst_mask", lane_mask, '0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_fifo_en", fifo_en, 1'b0);
      chk("arst_done", Done, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      fq.delete();
      @(negedge clk);
      chk("post_rst_idle", busy, 1'b0);

      // size_valid during SEND must not disturb the frame
      out_ready = 1'b0;
      preload(11, 4); sb_frame(11, 4); start(4);
      wait_valid(tv);
      size_valid = 1'b1; output_size = CW'(2);
      @(negedge clk);
      size_valid = 1'b0;
`ifdef CONV_PACKER_ERR_EN
      chk("size_err_pulse", size_err, 1'b1);
`endif
      chk("ignored_still_valid", Valid, 1'b1);
      @(negedge clk);
`ifdef CONV_PACKER_ERR_EN
      chk("size_err_single", size_err, 1'b0);
`endif
      out_ready = 1'b1;
      wait_done();
      chk("ignored_no_restart", busy, 1'b0);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_result_packer.md
# conv_result_packer

Output-side packer for the convolution core. It drains 32-bit accumulator results from the result FIFO and packs LANES results into one wide output beat. It adds a valid/ready handshake and a per-lane mask for a partial final beat. It supersedes the fixed 4-lane, no-backpressure output path between the result FIFO and the core's `Dataout`/`Valid`/`Done` pins.

## Interface
- DATA_W, 32, width of one result word
- LANES, 4, result words per output beat (≥1)
- CNT_W, 8, width of the frame result count
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- size_valid  in  1  one-cycle pulse; starts a frame, captures output_size
- output_size  in  CNT_W  number of result words in the frame
- fifo_empty  in  1  result FIFO empty flag
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_en
- fifo_en  out  1  FIFO read strobe
- out_ready  in  1  downstream accepts beat when Valid&out_ready
- Dataout  out  DATA_W*LANES  packed beat; lane k = bits [k*DATA_W +: DATA_W]
- Valid  out  1  beat valid
- lane_mask  out  LANES  bit k set = lane k holds a result
- Done  out  1  one-cycle pulse, frame complete
- busy  out  1  high in any state except IDLE
- size_err  out  1  one-cycle pulse, size_valid rejected (only with CONV_PACKER_ERR_EN)

## Operation
- FSM: IDLE, FILL, SEND, DONE.
- IDLE: on size_valid, latch remaining=output_size. Go to DONE if output_size==0, else go to FILL with lane counters cleared.
- beat_target = min(LANES, remaining).
- FILL: fifo_en = !fifo_empty && req_cnt<beat_target (combinational). Each fifo_en sets a read-pending flag. Next cycle fifo_data is written into lane got_cnt, and got_cnt increments. Earliest-read word lands in lane 0.
- FILL exit: on the edge where got_cnt reaches beat_target, load lane_mask = (1<<beat_target)-1 and go to SEND. Lanes ≥beat_target are zero in Dataout.
- SEND: Valid=1, and Dataout/lane_mask are held stable. fifo_en=0.
- On Valid&out_ready: remaining -= beat_target, clear the lane buffer and counters. Go to DONE if remaining becomes 0, else go to FILL.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- size_valid outside IDLE is ignored. The frame in progress is unaffected.
- Reset (async, any state): state goes to IDLE, all counters clear, and the lane buffer clears. FIFO contents are not drained.

## Timing
- Reset values: Dataout=0, Valid=0, lane_mask=0, Done=0, busy=0, fifo_en=0, size_err=0.
- All outputs except fifo_en are registered or state-decoded.
- Throughput in FILL: one word per cycle while FIFO is non-empty.
- Latency: size_valid in cycle T with FIFO holding ≥LANES words gives fifo_en in T+1..T+LANES and Valid first high in T+LANES+2.
- Beat accepted at edge E with remaining hitting 0 gives Done high in the cycle after E.
- Beat accepted at edge E with words left gives the next fifo_en in the cycle after E.
- Empty FIFO stalls FILL indefinitely. No fifo_en is issued while fifo_empty=1.
- Valid with out_ready low: beat is held with no limit, and no FIFO reads occur.
- Counter widths:
  - remaining is CNT_W bits and never underflows.
  - req_cnt/got_cnt are $clog2(LANES+1) bits.
- output_size = 2^CNT_W-1 is legal.

## Configuration
- CONV_PACKER_ERR_EN defined:
  - size_err port exists.
  - A size_valid pulse while busy=1 gives size_err=1 in the following cycle, for one cycle. The pulse is otherwise ignored.
- CONV_PACKER_ERR_EN undefined: the size_err port is absent, and a rejected size_valid is silently dropped.

## Test plan
- LANES=4, FIFO preloaded 1..8, output_size=8, out_ready=1:
  - First beat: Dataout lanes0..3 = 1,2,3,4, lane_mask=4'hF, Valid at T+6.
  - Second beat: lanes 5,6,7,8.
  - Done one cycle after second accept.
- output_size=6, FIFO 1..6: second beat lanes0..1 = 5,6, lanes2..3 = 0, lane_mask=4'b0011, then Done.
- Backpressure: out_ready=0 for 5 cycles during SEND gives Valid held, Dataout/lane_mask constant, fifo_en=0 throughout. Accept on the 6th cycle.
- fifo_empty toggled every other cycle during FILL: fifo_en never high with fifo_empty=1, and beat order is still 1,2,3,4.
- output_size=0: Done pulse in the cycle after the size_valid edge, Valid never asserted, busy high for one cycle.
- Reset and error cases:
  - rst low mid-FILL gives all outputs 0 asynchronously; after release the block is in IDLE.
  - With CONV_PACKER_ERR_EN, size_valid during SEND gives a single size_err pulse, and the frame completes with the original size.
